// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - value source / timebase to scanner bundle with display pin outputs
interface display_scanner_if #(
  parameter int N_DIGITS = 4
) ();
  localparam int DW = $clog2(N_DIGITS);

  logic                  next_data;
  logic [4*N_DIGITS-1:0] value_bcd;
  logic                  value_neg;
  logic                  blank_lz;
  logic                  value_load;
  logic [N_DIGITS-1:0]   anode;
  logic [6:0]            seg;
  logic [DW-1:0]         digit_sel;
  logic                  frame_done;
  logic                  load_pending;

  modport master (
    output next_data, value_bcd, value_neg, blank_lz, value_load,
    input  anode, seg, digit_sel, frame_done, load_pending
  );

  modport slave (
    input  next_data, value_bcd, value_neg, blank_lz, value_load,
    output anode, seg, digit_sel, frame_done, load_pending
  );
endinterface

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - frame-synchronous multiplexed 7-segment digit scanner
module display_scanner #(
  parameter int N_DIGITS       = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic             clk,
  input logic             reset,
  display_scanner_if.slave bus
);
  localparam int DW = $clog2(N_DIGITS);
  localparam logic [DW-1:0] LAST = DW'(N_DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0] GLYPH_MINUS = 7'h40;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state, state_nxt;
  logic [DW-1:0]         dig, dig_nxt;
  logic [4*N_DIGITS-1:0] stage_bcd, stage_bcd_nxt;
  logic                  stage_neg, stage_neg_nxt;
  logic                  stage_blz, stage_blz_nxt;
  logic                  pend, pend_nxt;
  logic [4*N_DIGITS-1:0] disp_bcd, disp_bcd_nxt;
  logic                  disp_neg, disp_neg_nxt;
  logic                  disp_blz, disp_blz_nxt;
  logic [N_DIGITS-1:0]   an_q, an_nxt;
  logic [6:0]            seg_q, seg_nxt;
  logic                  fd_q, fd_nxt;

  logic                  boundary;
  logic [DW-1:0]         msd;
  logic [DW-1:0]         minus_pos;
  logic [3:0]            nib;
  logic [6:0]            glyph;
  logic [6:0]            seg_hi;
  logic [N_DIGITS-1:0]   an_hi;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Next state, capture path and the pin pattern for the digit about to be driven.
  // Segments are decoded from the post-update display register so a boundary
  // shows the freshly committed value on digit 0 in the same cycle.
  always_comb begin
    state_nxt     = state;
    dig_nxt       = dig;
    stage_bcd_nxt = stage_bcd;
    stage_neg_nxt = stage_neg;
    stage_blz_nxt = stage_blz;
    pend_nxt      = pend;
    disp_bcd_nxt  = disp_bcd;
    disp_neg_nxt  = disp_neg;
    disp_blz_nxt  = disp_blz;
    msd           = '0;
    minus_pos     = LAST;
    nib           = 4'h0;
    glyph         = 7'h00;
    seg_hi        = 7'h00;
    an_hi         = '0;

    boundary = bus.next_data && ((state == IDLE) || (dig == LAST));
    fd_nxt   = boundary;

    if (bus.next_data) begin
      if (state == IDLE) begin
        state_nxt = SCAN;
        dig_nxt   = '0;
      end else begin
        dig_nxt = (dig == LAST) ? '0 : dig + 1'b1;
      end
    end

    // staging always follows the latest load so it never holds a stale value
    if (bus.value_load) begin
      stage_bcd_nxt = bus.value_bcd;
      stage_neg_nxt = bus.value_neg;
      stage_blz_nxt = bus.blank_lz;
    end

    if (boundary) begin
      pend_nxt = 1'b0;
      if (bus.value_load) begin
        disp_bcd_nxt = bus.value_bcd;
        disp_neg_nxt = bus.value_neg;
        disp_blz_nxt = bus.blank_lz;
      end else if (pend) begin
        disp_bcd_nxt = stage_bcd;
        disp_neg_nxt = stage_neg;
        disp_blz_nxt = stage_blz;
      end
    end else if (bus.value_load) begin
      pend_nxt = 1'b1;
    end

    for (int i = 0; i < N_DIGITS; i++) begin
      if (disp_bcd_nxt[4*i +: 4] != 4'h0) msd = DW'(i);
    end

    if (disp_blz_nxt) minus_pos = (msd == LAST) ? LAST : msd + 1'b1;

    nib = disp_bcd_nxt[{dig_nxt, 2'b00} +: 4];
    if (disp_neg_nxt && (dig_nxt == minus_pos)) glyph = GLYPH_MINUS;
    else if (disp_blz_nxt && (dig_nxt > msd))   glyph = 7'h00;
    else                                        glyph = hex7(nib);

    if (state_nxt == SCAN) begin
      seg_hi = glyph;
      an_hi  = N_DIGITS'(1) << dig_nxt;
    end

    seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    an_nxt  = (AN_ACTIVE_LOW != 0)  ? ~an_hi  : an_hi;
  end

  // State and output registers; reset discards any staged value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dig       <= '0;
      stage_bcd <= '0;
      stage_neg <= 1'b0;
      stage_blz <= 1'b0;
      pend      <= 1'b0;
      disp_bcd  <= '0;
      disp_neg  <= 1'b0;
      disp_blz  <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_OFF;
      fd_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dig       <= dig_nxt;
      stage_bcd <= stage_bcd_nxt;
      stage_neg <= stage_neg_nxt;
      stage_blz <= stage_blz_nxt;
      pend      <= pend_nxt;
      disp_bcd  <= disp_bcd_nxt;
      disp_neg  <= disp_neg_nxt;
      disp_blz  <= disp_blz_nxt;
      an_q      <= an_nxt;
      seg_q     <= seg_nxt;
      fd_q      <= fd_nxt;
    end
  end

  assign bus.anode        = an_q;
  assign bus.seg          = seg_q;
  assign bus.digit_sel    = dig;
  assign bus.frame_done   = fd_q;
  assign bus.load_pending = pend;
endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - randomized and directed bench for display_scanner
module tb_display_scanner;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  display_scanner_if #(.N_DIGITS(N)) bus ();

  display_scanner #(
    .N_DIGITS(N),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model: what the display should look like, in plain terms
  bit          m_scan = 0;
  int          m_dig = 0;
  logic [15:0] m_disp = 0, m_stage = 0;
  bit          m_dneg = 0, m_dblz = 0, m_sneg = 0, m_sblz = 0;
  bit          m_pend = 0, m_fd = 0;
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;
  bit          m_bnd;

  function automatic logic [6:0] hex_of(int d);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[d];
  endfunction

  function automatic logic [6:0] shown(logic [15:0] v, bit neg, bit blz, int d);
    int msd = 0;
    int mpos;
    for (int i = 0; i < N; i++) if (((v >> (4 * i)) & 16'hF) != 0) msd = i;
    mpos = blz ? ((msd + 1 < N) ? msd + 1 : N - 1) : N - 1;
    if (neg && d == mpos) return 7'h40;
    if (blz && d > msd) return 7'h00;
    return hex_of(int'((v >> (4 * d)) & 16'hF));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_scan = 0; m_dig = 0; m_disp = 0; m_stage = 0;
      m_dneg = 0; m_dblz = 0; m_sneg = 0; m_sblz = 0;
      m_pend = 0; m_fd = 0;
    end else begin
      m_bnd = bus.next_data && (!m_scan || m_dig == N - 1);
      m_fd = m_bnd;
      if (bus.next_data) begin
        if (!m_scan) begin m_scan = 1; m_dig = 0; end
        else m_dig = (m_dig + 1) % N;
      end
      if (m_bnd) begin
        if (bus.value_load) begin
          m_disp = bus.value_bcd; m_dneg = bus.value_neg; m_dblz = bus.blank_lz;
        end else if (m_pend) begin
          m_disp = m_stage; m_dneg = m_sneg; m_dblz = m_sblz;
        end
        m_pend = 0;
      end else if (bus.value_load) begin
        m_pend = 1;
      end
      if (bus.value_load) begin
        m_stage = bus.value_bcd; m_sneg = bus.value_neg; m_sblz = bus.blank_lz;
      end
    end
    if (m_scan) begin
      m_an  = ~(4'b0001 << m_dig);
      m_seg = ~shown(m_disp, m_dneg, m_dblz, m_dig);
    end else begin
      m_an  = 4'hF;
      m_seg = 7'h7F;
    end
  end

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // every cycle the pins must match the model
  always @(negedge clk) begin
    chk("anode", int'(bus.anode), int'(m_an));
    chk("seg", int'(bus.seg), int'(m_seg));
    chk("digit_sel", int'(bus.digit_sel), m_dig);
    chk("frame_done", int'(bus.frame_done), int'(m_fd));
    chk("load_pending", int'(bus.load_pending), int'(m_pend));
  end

  task automatic step(bit nd, bit ld, logic [15:0] v, bit neg, bit blz);
    bus.next_data  = nd;
    bus.value_load = ld;
    if (ld) begin
      bus.value_bcd = v;
      bus.value_neg = neg;
      bus.blank_lz  = blz;
    end
    @(posedge clk);
    #1;
    bus.next_data  = 1'b0;
    bus.value_load = 1'b0;
    reset          = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    bus.next_data = 0; bus.value_load = 0; bus.value_bcd = 0;
    bus.value_neg = 0; bus.blank_lz = 0;
    @(posedge clk);
    step(0, 0, 0, 0, 0);
    chk("rst_anode", int'(bus.anode), 'hF);
    chk("rst_seg", int'(bus.seg), 'h7F);
    chk("rst_pending", int'(bus.load_pending), 0);
    chk("rst_digit", int'(bus.digit_sel), 0);

    step(1, 0, 0, 0, 0);
    chk("first_anode", int'(bus.anode), 'hE);
    chk("first_seg", int'(bus.seg), 'h40);
    chk("first_fd", int'(bus.frame_done), 1);
    step(0, 0, 0, 0, 0);
    chk("fd_one_cycle", int'(bus.frame_done), 0);

    step(0, 1, 16'h1234, 0, 0);
    chk("pend_1234", int'(bus.load_pending), 1);
    repeat (3) step(1, 0, 0, 0, 0);
    chk("old_d3", int'(bus.seg), 'h40);
    step(1, 0, 0, 0, 0);
    chk("v1234_d0", int'(bus.seg), 'h19);
    chk("wrap_fd", int'(bus.frame_done), 1);
    chk("wrap_pend", int'(bus.load_pending), 0);
    step(1, 0, 0, 0, 0); chk("v1234_d1", int'(bus.seg), 'h30);
    step(1, 0, 0, 0, 0); chk("v1234_d2", int'(bus.seg), 'h24);
    step(1, 0, 0, 0, 0); chk("v1234_d3", int'(bus.seg), 'h79);

    step(0, 1, 16'h0042, 1, 1);
    step(1, 0, 0, 0, 0); chk("v42_d0", int'(bus.seg), 'h24);
    step(1, 0, 0, 0, 0); chk("v42_d1", int'(bus.seg), 'h19);
    step(1, 0, 0, 0, 0); chk("v42_minus", int'(bus.seg), 'h3F);
    step(1, 0, 0, 0, 0); chk("v42_blank", int'(bus.seg), 'h7F);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 16'h9999, 0, 0);
    chk("pend_9999", int'(bus.load_pending), 1);
    step(1, 0, 0, 0, 0); chk("hold_old_d2", int'(bus.seg), 'h3F);
    step(1, 0, 0, 0, 0); chk("hold_old_d3", int'(bus.seg), 'h7F);
    step(1, 0, 0, 0, 0);
    chk("v9999_d0", int'(bus.seg), 'h10);
    chk("pend_drop", int'(bus.load_pending), 0);

    repeat (3) step(1, 0, 0, 0, 0);
    step(1, 1, 16'h0005, 0, 0);
    chk("coinc_d0", int'(bus.seg), 'h12);
    chk("coinc_pend", int'(bus.load_pending), 0);

    step(1, 0, 0, 0, 0);
    step(0, 1, 16'h7777, 0, 0);
    chk("pend_7777", int'(bus.load_pending), 1);
    reset = 1'b1;
    step(1, 1, 16'h3333, 0, 0);
    chk("mid_rst_anode", int'(bus.anode), 'hF);
    chk("mid_rst_seg", int'(bus.seg), 'h7F);
    chk("mid_rst_pend", int'(bus.load_pending), 0);
    step(1, 0, 0, 0, 0);
    chk("after_rst_seg", int'(bus.seg), 'h40);

    for (int k = 0; k < 3000; k++) begin
      v = 16'($urandom);
      case ($urandom % 5)
        0: v = v & 16'h0FFF;
        1: v = v & 16'h00FF;
        2: v = v & 16'h000F;
        3: v = 16'h0000;
        default: ;
      endcase
      if ($urandom % 250 == 0) reset = 1'b1;
      step(bit'($urandom % 2), ($urandom % 8) == 0, v,
           bit'($urandom % 2), bit'($urandom % 2));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/display_scanner.md
# display_scanner

Consumer side of the display timebase: advances one digit per `next_data` pulse, drives a time-multiplexed N-digit 7-segment display, and holds the calculator value in a frame-synchronous shadow register so digits never tear mid-frame. It sits between the calculator datapath (value source) and the board anode/segment pins. The display timebase supplies `next_data` as a one-cycle enable.

## Interface
- `N_DIGITS`, 4, number of multiplexed digits (2..8)
- `SEG_ACTIVE_LOW`, 1, 1 = `seg` driven inverted (common-anode board)
- `AN_ACTIVE_LOW`, 1, 1 = `anode` select bit driven low
- `clk`  in  1  system clock; one clock domain only
- `reset`  in  1  synchronous, active-high
- `next_data`  in  1  one-cycle enable from display timebase; advance one digit
- `value_bcd`  in  4*N_DIGITS  digit nibbles, [3:0] = digit 0 (rightmost)
- `value_neg`  in  1  show minus sign
- `blank_lz`  in  1  blank leading zeros
- `value_load`  in  1  one-cycle strobe: capture `value_bcd`/`value_neg`/`blank_lz`
- `anode`  out  N_DIGITS  one-hot digit select (polarity per `AN_ACTIVE_LOW`)
- `seg`  out  7  segments {g,f,e,d,c,b,a} (polarity per `SEG_ACTIVE_LOW`)
- `digit_sel`  out  clog2(N_DIGITS)  index of the digit currently driven
- `frame_done`  out  1  one-cycle pulse when digit 0 of a new frame is driven
- `load_pending`  out  1  staged value waiting for frame boundary

## Operation
- FSM: IDLE, SCAN. Reset → IDLE. IDLE: all anodes inactive, all segments off. The first `next_data` → SCAN, drives digit 0.
- SCAN: each `next_data` sets `digit_sel` ← `digit_sel`+1, wrapping N_DIGITS-1 → 0. No `next_data` → outputs hold.
- Capture path: `value_load` copies inputs into the staging register and sets `load_pending` (last load wins). Staging copies into the display register on the frame boundary and clears `load_pending`. The frame boundary is the `next_data` that moves to digit 0 (IDLE→SCAN or wrap).
- `value_load` in the same cycle as a frame boundary: new inputs go straight to the display register; `load_pending` stays 0.
- Decode (active-high, before polarity): full hex.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Minus = 40. Blank = 00.
- Leading-zero blanking (`blank_lz`=1):
  - msd = index of the most significant nonzero nibble (0 if all zero).
  - Digits above msd are blank. Digit 0 is never blanked.
- Minus sign (`value_neg`=1):
  - Position = min(msd+1, N_DIGITS-1) with blanking on; N_DIGITS-1 with blanking off.
  - The digit at that position shows 40, overriding any nibble.
- msd, blanking and minus position are computed from the display register only, never from live inputs.

## Timing
- All outputs registered. Effect of `next_data` at edge k is visible after edge k (one-cycle latency).
- `anode`, `seg` and `digit_sel` change together in the same cycle: no cycle with a new anode and old segments.
- `frame_done` is high for exactly the cycle after the boundary edge, coincident with first drive of digit 0. It does not pulse when `next_data` is absent.
- `load_pending` rises the cycle after `value_load`. It falls the cycle after the boundary edge.
- Back-to-back `next_data` (every cycle) is legal; each pulse advances one digit.
- Reset values:
  - state IDLE, `digit_sel`=0
  - `anode` all inactive (all 1s when `AN_ACTIVE_LOW`)
  - `seg` all off (7'h7F when `SEG_ACTIVE_LOW`)
  - `frame_done`=0, `load_pending`=0
  - staging and display registers all zero, neg=0, blank_lz=0
- Reset mid-scan or mid-pending discards the staged value. Reset dominates a simultaneous `next_data`/`value_load`.

## Test plan
- Reset, then one `next_data` with defaults → `anode`=4'b1110, `seg`=~7'h3F=7'h40, `digit_sel`=0, `frame_done`=1 for one cycle.
- Load 0x1234, blank_lz=0, then 4 `next_data` pulses → digits 0..3 show 4,3,2,1 (active-low 19,30,24,79). On the wrap, `frame_done` pulses again.
- Load 0x0042, neg=1, blank_lz=1, then scan a full frame → digit0=2, digit1=4, digit2 shows `-` (active-low 3F), digit3 blank (7F).
- While scanning digit 1, load 0x9999 → `load_pending`=1. Digits 2–3 still show the old value. At the wrap, digit 0 shows 9 and `load_pending` drops.
- `value_load` of 0x0005 coincident with the wrap edge → digit 0 shows 5 immediately; `load_pending` never rises.
- Reset asserted mid-frame with `load_pending`=1 and `next_data` high → IDLE, anodes off, `load_pending`=0. The next `next_data` shows 0 on digit 0.
